// File: rtl/link_tx_arbiter_pkg.sv
// Shared constants for the serial-link transmit arbiter: item geometry,
// start-timeout default, FSM encodings and a saturating-increment helper.
package link_tx_arbiter_pkg;

  localparam int unsigned PAYLOAD_SIZE = 8;
  localparam int unsigned ADDR_SZ      = 4;
  localparam int unsigned LTA_ITEM_W   = PAYLOAD_SIZE + ADDR_SZ;
  localparam int unsigned LTA_START_TO = 4;
  localparam int unsigned RETRY_W      = 8;

  localparam logic [1:0] LTA_IDLE       = 2'd0;
  localparam logic [1:0] LTA_ISSUE      = 2'd1;
  localparam logic [1:0] LTA_WAIT_START = 2'd2;
  localparam logic [1:0] LTA_WAIT_DONE  = 2'd3;

  // Retry counter sticks at all-ones instead of wrapping.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searched from
// ptr+1 upward, wrapping modulo N; returns one-hot grant and its index.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [IDX_W:0] sh;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_first;
  logic [N-1:0]   idx_mask [IDX_W];

  // Rotate so the search starts at bit 0, isolate the lowest set bit, rotate back.
  assign sh        = {1'b0, ptr} + (IDX_W+1)'(1);
  assign rot       = N'({req, req} >> sh);
  assign rot_first = rot & (~rot + N'(1));
  assign gnt_c     = N'((({rot_first, rot_first}) << sh) >> N);
  assign any_c     = |req;

  for (genvar b = 0; b < IDX_W; b++) begin : g_idx
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign idx_mask[b][i] = 1'((i >> b) & 1);
    end
    assign idx_c[b] = |(gnt_c & idx_mask[b]);
  end

endmodule

// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one dclk_tx transmitter between N_SRC
// requesters; issues req, retries on start timeout, tracks tx_busy to completion.
module link_tx_arbiter
  import link_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned ITEM_W   = LTA_ITEM_W,
  parameter int unsigned START_TO = LTA_START_TO
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_req,
  input  logic [N_SRC*ITEM_W-1:0]    src_item,
  output logic [N_SRC-1:0]           src_ack,
  output logic                       tx_req,
  output logic [ITEM_W-1:0]          tx_item,
  input  logic                       tx_busy,
  input  logic                       channel_busy,
  output logic [ID_W-1:0]            grant_id,
  output logic                       arb_busy,
  output logic [RETRY_W-1:0]         retry_cnt
);

  localparam int unsigned TO_W = (START_TO < 2) ? 1 : $clog2(START_TO);

  logic [1:0]         state, state_d;
  logic [TO_W-1:0]    to_cnt, to_cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic [ITEM_W-1:0]  item_d;
  logic [ID_W-1:0]    grant_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [N_SRC-1:0]   ack_d;

  logic [N_SRC-1:0]   pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [ITEM_W-1:0]  items [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_items
    assign items[i] = src_item[i*ITEM_W +: ITEM_W];
  end

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (src_req),
    .ptr   (ptr),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state;
    to_cnt_d = to_cnt;
    retry_d  = retry_cnt;
    item_d   = tx_item;
    grant_d  = grant_id;
    ptr_d    = ptr;
    ack_d    = '0;
    case (state)
      LTA_IDLE: begin
        if (pick_any && !tx_busy && !channel_busy) begin
          item_d  = items[pick_idx];
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          ack_d   = pick_gnt;
          state_d = LTA_ISSUE;
        end
      end
      LTA_ISSUE: begin
        to_cnt_d = '0;
        state_d  = LTA_WAIT_START;
      end
      LTA_WAIT_START: begin
        if (tx_busy) begin
          state_d = LTA_WAIT_DONE;
        end else if (to_cnt == TO_W'(START_TO - 1)) begin
          // Transmitter never started: reissue the same item; no new ack.
          to_cnt_d = '0;
          retry_d  = sat_inc(retry_cnt);
          state_d  = LTA_ISSUE;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end
      LTA_WAIT_DONE: begin
        if (!tx_busy) state_d = LTA_IDLE;
      end
      default: state_d = LTA_IDLE;
    endcase
  end

  // State and registered outputs; tx_req/arb_busy are registered decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LTA_IDLE;
      to_cnt    <= '0;
      retry_cnt <= '0;
      tx_item   <= '0;
      grant_id  <= '0;
      ptr       <= ID_W'(N_SRC - 1);
      src_ack   <= '0;
      tx_req    <= 1'b0;
      arb_busy  <= 1'b0;
    end else begin
      state     <= state_d;
      to_cnt    <= to_cnt_d;
      retry_cnt <= retry_d;
      tx_item   <= item_d;
      grant_id  <= grant_d;
      ptr       <= ptr_d;
      src_ack   <= ack_d;
      tx_req    <= (state_d == LTA_ISSUE);
      arb_busy  <= (state_d != LTA_IDLE);
    end
  end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a timestamp-based model.
module tb_link_tx_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned ITEM_W   = 12;
  localparam int unsigned START_TO = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          src_req;
  logic [N*ITEM_W-1:0]   src_item;
  logic [N-1:0]          src_ack;
  logic                  tx_req;
  logic [ITEM_W-1:0]     tx_item;
  logic                  tx_busy;
  logic                  channel_busy;
  logic [ID_W-1:0]       grant_id;
  logic                  arb_busy;
  logic [7:0]            retry_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                m_busy, m_started;
  int                m_issue_cyc, m_ptr, m_grant, m_retry;
  logic [ITEM_W-1:0] m_item;
  int                cyc = 0;

  // Fake transmitter state
  bit tx_auto, tx_rand, tx_spur;
  int tx_wait, tx_left, cfg_delay, cfg_len;

  always #5 clk = ~clk;

  link_tx_arbiter #(
    .N_SRC    (N),
    .ID_W     (ID_W),
    .ITEM_W   (ITEM_W),
    .START_TO (START_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_req      (src_req),
    .src_item     (src_item),
    .src_ack      (src_ack),
    .tx_req       (tx_req),
    .tx_item      (tx_item),
    .tx_busy      (tx_busy),
    .channel_busy (channel_busy),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .retry_cnt    (retry_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: sample inputs at the edge, advance the model, compare just after.
  task automatic step();
    logic [N-1:0]        s_req;
    logic [N*ITEM_W-1:0] s_item;
    logic                s_busy, s_ch, s_rst;
    logic [N-1:0]        exp_ack;
    bit                  exp_req;
    int                  w;
    @(posedge clk);
    s_req = src_req; s_item = src_item; s_busy = tx_busy; s_ch = channel_busy; s_rst = reset;
    cyc++;
    exp_ack = '0;
    exp_req = 1'b0;
    w = -1;
    if (s_rst) begin
      m_busy = 0; m_started = 0; m_ptr = N - 1; m_grant = 0; m_item = '0; m_retry = 0;
    end else if (!m_busy) begin
      if (|s_req && !s_busy && !s_ch) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (w < 0 && s_req[j]) w = j;
        end
        m_busy = 1; m_started = 0; m_issue_cyc = cyc;
        m_item = s_item[w*ITEM_W +: ITEM_W];
        m_grant = w; m_ptr = w;
        exp_req = 1'b1;
        exp_ack[w] = 1'b1;
      end
    end else if (!m_started) begin
      if ((cyc - 1) > m_issue_cyc && s_busy) begin
        m_started = 1;
      end else if ((cyc - 1 - m_issue_cyc) == START_TO) begin
        m_issue_cyc = cyc;
        exp_req = 1'b1;
        if (m_retry < 255) m_retry++;
      end
    end else if (!s_busy) begin
      m_busy = 0;
    end
    #1;
    chk("src_ack",   32'(src_ack),   32'(exp_ack));
    chk("tx_req",    32'(tx_req),    32'(exp_req));
    chk("tx_item",   32'(tx_item),   32'(m_item));
    chk("grant_id",  32'(grant_id),  32'(m_grant));
    chk("arb_busy",  32'(arb_busy),  32'(m_busy));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    @(negedge clk);
  endtask

  // Transmitter stand-in: tx_busy rises some cycles after a req, stays for a frame.
  task automatic drive_tx();
    if (!tx_auto) return;
    if (tx_req) tx_wait = tx_rand ? int'($urandom_range(1, 6)) : cfg_delay;
    else if (tx_spur && tx_wait == 0 && tx_left == 0 && $urandom_range(0, 39) == 0) tx_left = 2;
    if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) tx_left = tx_rand ? int'($urandom_range(1, 8)) : cfg_len;
    end
    tx_busy = (tx_left > 0);
    if (tx_left > 0) tx_left--;
  endtask

  task automatic cycle();
    drive_tx();
    step();
  endtask

  task automatic rand_sources();
    for (int i = 0; i < N; i++) begin
      if (src_ack[i]) begin
        if ($urandom_range(0, 1) == 1) begin
          src_req[i] = 1'b1;
          src_item[i*ITEM_W +: ITEM_W] = ITEM_W'($urandom);
        end else begin
          src_req[i] = 1'b0;
        end
      end else if (!src_req[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          src_req[i] = 1'b1;
          src_item[i*ITEM_W +: ITEM_W] = ITEM_W'($urandom);
        end
      end else if ($urandom_range(0, 49) == 0) begin
        src_req[i] = 1'b0;
      end
    end
    channel_busy = ($urandom_range(0, 4) == 0);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while (arb_busy && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("idle_wait", 32'(arb_busy), 32'd0);
  endtask

  initial begin
    int exp_order [5];
    int got;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1; src_req = '0; src_item = '0; tx_busy = 1'b0; channel_busy = 1'b0;
    tx_auto = 0; tx_rand = 0; tx_spur = 0; tx_wait = 0; tx_left = 0; cfg_delay = 2; cfg_len = 3;
    m_busy = 0; m_started = 0; m_ptr = N - 1; m_grant = 0; m_item = '0; m_retry = 0; m_issue_cyc = 0;

    // Reset then a single request from source 2
    @(negedge clk);
    repeat (4) step();
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    reset = 1'b0;
    src_req = 4'b0100;
    src_item[2*ITEM_W +: ITEM_W] = 12'h015;
    step();
    chk("single_ack", 32'(src_ack), 32'h4);
    chk("single_req", 32'(tx_req), 32'd1);
    chk("single_item", 32'(tx_item), 32'h015);
    chk("single_grant", 32'(grant_id), 32'd2);
    src_req = '0;
    tx_auto = 1;
    run_until_idle(50);

    // Fairness: everyone requesting from a fresh reset
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    src_req = 4'b1111;
    for (int i = 0; i < N; i++) src_item[i*ITEM_W +: ITEM_W] = ITEM_W'(12'h100 + i);
    got = 0;
    for (int n = 0; n < 200 && got < 5; n++) begin
      cycle();
      if (tx_req) begin
        chk("fair_order", 32'(grant_id), 32'(exp_order[got]));
        got++;
      end
    end
    chk("fair_count", 32'(got), 32'd5);
    src_req = '0;
    run_until_idle(50);

    // Downstream blocked, then released
    tx_auto = 0; tx_busy = 1'b0; channel_busy = 1'b1;
    src_req = 4'b0001;
    src_item[0 +: ITEM_W] = 12'h0A5;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("blocked_req", 32'(tx_req), 32'd0);
      chk("blocked_ack", 32'(src_ack), 32'd0);
    end
    channel_busy = 1'b0;
    step();
    chk("unblock_req", 32'(tx_req), 32'd1);
    chk("unblock_ack", 32'(src_ack), 32'h1);
    src_req = '0;

    // Start timeout: tx_busy never rises
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("retry_req", 32'(tx_req), 32'((k % 5) == 0));
      chk("retry_ack", 32'(src_ack), 32'd0);
      chk("retry_item", 32'(tx_item), 32'h0A5);
    end
    chk("retry_cnt3", 32'(retry_cnt), 32'd3);

    // Back-to-back: 20-cycle frame, then source 1 must issue 2 cycles after busy falls
    src_req = 4'b0011;
    src_item[0 +: ITEM_W] = 12'h0B0;
    src_item[ITEM_W +: ITEM_W] = 12'h0B1;
    tx_busy = 1'b1;
    repeat (20) step();
    tx_busy = 1'b0;
    step();
    chk("b2b_gap", 32'(tx_req), 32'd0);
    step();
    chk("b2b_req", 32'(tx_req), 32'd1);
    chk("b2b_grant", 32'(grant_id), 32'd1);
    chk("b2b_ack", 32'(src_ack), 32'h2);
    chk("b2b_item", 32'(tx_item), 32'h0B1);
    src_req = 4'b0001;

    // Reset during WAIT_DONE
    tx_busy = 1'b1;
    repeat (3) step();
    chk("pre_reset_busy", 32'(arb_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_tx_req", 32'(tx_req), 32'd0);
    chk("async_ack", 32'(src_ack), 32'd0);
    chk("async_item", 32'(tx_item), 32'd0);
    chk("async_grant", 32'(grant_id), 32'd0);
    chk("async_busy", 32'(arb_busy), 32'd0);
    chk("async_retry", 32'(retry_cnt), 32'd0);
    repeat (2) step();
    reset = 1'b0; tx_busy = 1'b0;
    src_req = 4'b1111;
    for (int i = 0; i < N; i++) src_item[i*ITEM_W +: ITEM_W] = ITEM_W'(12'h0C0 + i);
    step();
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    chk("post_rst_ack", 32'(src_ack), 32'h1);
    chk("post_rst_item", 32'(tx_item), 32'h0C0);
    src_req = '0;
    tx_auto = 1;
    run_until_idle(100);

    // Randomized traffic
    tx_rand = 1; tx_spur = 1;
    for (int n = 0; n < 3000; n++) begin
      rand_sources();
      cycle();
    end
    src_req = '0; channel_busy = 1'b0; tx_spur = 0;
    run_until_idle(500);

    // Retry counter saturation
    tx_auto = 0; tx_busy = 1'b0;
    src_req = 4'b0001;
    src_item[0 +: ITEM_W] = 12'h3C3;
    repeat (1300) step();
    chk("retry_sat", 32'(retry_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
